// File: rtl/dmem_ctrl_pkg.sv
// Shared types and helpers for the data-memory arbiter slice.
// Holds the FSM state type, width defaults and the sub-word merge helper.
package dmem_ctrl_pkg;

   localparam int unsigned ADDR_W_DEF = 32;
   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned STRB_W     = DATA_W_DEF / 8;

   typedef enum logic [2:0] {
      IDLE,
      RD,
      CAP,
      MERGE_WR,
      WR,
      RESP
   } state_t;

   function automatic logic [7:0] merge_byte(input logic [7:0] old_b,
                                             input logic [7:0] new_b,
                                             input logic       en);
      return en ? new_b : old_b;
   endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester channel: valid/ready request plus one-cycle response pulse.
interface dmem_arbiter_if
   import dmem_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
);
   logic                  valid;
   logic                  ready;
   logic                  we;
   logic [ADDR_W-1:0]     addr;
   logic [DATA_W-1:0]     wdata;
   logic [DATA_W/8-1:0]   wstrb;
   logic                  rvalid;
   logic [DATA_W-1:0]     rdata;

   modport master (output valid, we, addr, wdata, wstrb,
                   input  ready, rvalid, rdata);
   modport slave  (input  valid, we, addr, wdata, wstrb,
                   output ready, rvalid, rdata);
endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; last_grant holds the index of the last winner.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] grant,
   output logic       last_grant
);

   always_comb begin
      grant = '0;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last_grant ? 2'b01 : 2'b10;
         default: grant = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         last_grant <= 1'b1;
      else if (advance && (grant != '0))
         last_grant <= grant[1];
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one word-addressed data memory between two requesters; sub-word
// stores are done as read-modify-write.
module dmem_arbiter
   import dmem_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   dmem_arbiter_if.slave     req0,
   dmem_arbiter_if.slave     req1,
   output logic [ADDR_W-1:0] mem_r_addr,
   output logic [ADDR_W-1:0] mem_w_addr,
   output logic              mem_read,
   output logic              mem_write,
   output logic [DATA_W-1:0] mem_data_in,
   input  logic [DATA_W-1:0] mem_data_out
);

   localparam int unsigned NBYTES = DATA_W / 8;

   state_t              state;
   logic [1:0]          grant;
   logic                last_grant;
   logic                accept;
   logic                sel_we;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_wdata;
   logic [NBYTES-1:0]   sel_wstrb;
   logic                we_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [NBYTES-1:0]   wstrb_q;
   logic [DATA_W-1:0]   merged;

   rr_arb2 u_arb (
      .clk        (clk),
      .rst        (rst),
      .req        ({req1.valid, req0.valid} & {2{state == IDLE}}),
      .advance    (accept),
      .grant      (grant),
      .last_grant (last_grant)
   );

   assign req0.ready = grant[0];
   assign req1.ready = grant[1];
   assign accept     = (req0.valid & grant[0]) | (req1.valid & grant[1]);

   always_comb begin
      sel_we    = grant[1] ? req1.we    : req0.we;
      sel_addr  = grant[1] ? req1.addr  : req0.addr;
      sel_wdata = grant[1] ? req1.wdata : req0.wdata;
      sel_wstrb = grant[1] ? req1.wstrb : req0.wstrb;
   end

   always_comb begin
      merged = '0;
      for (int unsigned i = 0; i < NBYTES; i++)
         merged[i*8 +: 8] = merge_byte(mem_data_out[i*8 +: 8], wdata_q[i*8 +: 8], wstrb_q[i]);
   end

   // last_grant is updated on accept, so it names the transaction owner
   // for the rest of the transaction.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         mem_r_addr  <= '0;
         mem_w_addr  <= '0;
         mem_read    <= 1'b0;
         mem_write   <= 1'b0;
         mem_data_in <= '0;
         req0.rvalid <= 1'b0;
         req1.rvalid <= 1'b0;
         req0.rdata  <= '0;
         req1.rdata  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  we_q    <= sel_we;
                  addr_q  <= sel_addr;
                  wdata_q <= sel_wdata;
                  wstrb_q <= sel_wstrb;
                  if (!sel_we || (sel_wstrb != '0 && sel_wstrb != '1)) begin
                     state      <= RD;
                     mem_read   <= 1'b1;
                     mem_r_addr <= sel_addr;
                  end else if (sel_wstrb == '1) begin
                     state       <= WR;
                     mem_write   <= 1'b1;
                     mem_w_addr  <= sel_addr;
                     mem_data_in <= sel_wdata;
                  end else begin
                     state       <= RESP;
                     req0.rvalid <= ~grant[1];
                     req1.rvalid <= grant[1];
                  end
               end
            end
            RD: begin
               mem_read <= 1'b0;
               state    <= CAP;
            end
            CAP: begin
               if (!we_q) begin
                  state       <= RESP;
                  req0.rvalid <= ~last_grant;
                  req1.rvalid <= last_grant;
                  if (last_grant) req1.rdata <= mem_data_out;
                  else            req0.rdata <= mem_data_out;
               end else begin
                  state       <= MERGE_WR;
                  mem_write   <= 1'b1;
                  mem_w_addr  <= addr_q;
                  mem_data_in <= merged;
               end
            end
            MERGE_WR, WR: begin
               mem_write   <= 1'b0;
               state       <= RESP;
               req0.rvalid <= ~last_grant;
               req1.rvalid <= last_grant;
            end
            RESP: begin
               state       <= IDLE;
               req0.rvalid <= 1'b0;
               req1.rvalid <= 1'b0;
               req0.rdata  <= '0;
               req1.rdata  <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
